// File: rtl/load_wb_unit.sv
// Load writeback unit: issues one word read per load, formats the returned
// byte/half/word with sign or zero extension and drives the register file
// write port for a single cycle. busy_o stalls the pipeline while a load is
// in flight; only one load is ever outstanding.
//
// Optional feature: define LOAD_MISALIGN_TRAP_EN to trap misaligned LH/LHU/LW
// through a one-cycle ERR state (err_o pulse, no memory access, no write).
// Without it err_o is tied low and misaligned loads read the containing word.
module load_wb_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_addr_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [4:0]  ld_rd_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic        rwr_en_o,
    output logic        dr_en_o,
    output logic [4:0]  rd_o,
    output logic [31:0] wr_data_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReq  = 3'd1,
        StWait = 3'd2,
        StWb   = 3'd3
`ifdef LOAD_MISALIGN_TRAP_EN
        ,
        StErr  = 3'd4
`endif
    } state_e;

    state_e      r_state;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic        r_busy;
    logic        r_rwr_en;
    logic [4:0]  r_rd_out;
    logic [31:0] r_wr_data;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt_data;

    // Format the incoming read word using the latched offset and load type
    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0:    w_byte = mem_rdata_i[7:0];
            2'd1:    w_byte = mem_rdata_i[15:8];
            2'd2:    w_byte = mem_rdata_i[23:16];
            default: w_byte = mem_rdata_i[31:24];
        endcase
        w_half = r_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (r_funct3)
            3'b000:  w_fmt_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_fmt_data = {24'h000000, w_byte};
            3'b001:  w_fmt_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_fmt_data = {16'h0000, w_half};
            // LW and the unused encodings 011/110/111 pass the word through
            default: w_fmt_data = mem_rdata_i;
        endcase
    end

`ifdef LOAD_MISALIGN_TRAP_EN
    logic w_misalign;

    // Halfword loads need addr[0]=0; word-formatted loads need addr[1:0]=0
    always_comb begin
        w_misalign = 1'b0;
        if (ld_funct3_i[1:0] == 2'b01) begin
            w_misalign = ld_addr_i[0];
        end else if (ld_funct3_i[1]) begin
            w_misalign = |ld_addr_i[1:0];
        end
    end

    logic r_err;
    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    // Load sequencer: state and every output are registered here
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= StIdle;
            r_off      <= 2'd0;
            r_funct3   <= 3'd0;
            r_rd       <= 5'd0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'd0;
            r_busy     <= 1'b0;
            r_rwr_en   <= 1'b0;
            r_rd_out   <= 5'd0;
            r_wr_data  <= 32'd0;
`ifdef LOAD_MISALIGN_TRAP_EN
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (ld_valid_i) begin
                        r_off    <= ld_addr_i[1:0];
                        r_funct3 <= ld_funct3_i;
                        r_rd     <= ld_rd_i;
                        r_busy   <= 1'b1;
`ifdef LOAD_MISALIGN_TRAP_EN
                        if (w_misalign) begin
                            r_state <= StErr;
                            r_err   <= 1'b1;
                        end else begin
`endif
                            r_state    <= StReq;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {ld_addr_i[31:2], 2'b00};
`ifdef LOAD_MISALIGN_TRAP_EN
                        end
`endif
                    end
                end
                StReq: begin
                    if (mem_gnt_i) begin
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= 32'd0;
                        // Data may come back in the grant cycle itself
                        if (mem_rvalid_i) begin
                            r_state   <= StWb;
                            r_rwr_en  <= 1'b1;
                            r_rd_out  <= r_rd;
                            r_wr_data <= w_fmt_data;
                        end else begin
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (mem_rvalid_i) begin
                        r_state   <= StWb;
                        r_rwr_en  <= 1'b1;
                        r_rd_out  <= r_rd;
                        r_wr_data <= w_fmt_data;
                    end
                end
                StWb: begin
                    r_state   <= StIdle;
                    r_rwr_en  <= 1'b0;
                    r_rd_out  <= 5'd0;
                    r_wr_data <= 32'd0;
                    r_busy    <= 1'b0;
                end
`ifdef LOAD_MISALIGN_TRAP_EN
                StErr: begin
                    r_state <= StIdle;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
`endif
                default: begin
                    r_state    <= StIdle;
                    r_mem_req  <= 1'b0;
                    r_mem_addr <= 32'd0;
                    r_busy     <= 1'b0;
                    r_rwr_en   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o  = r_mem_req;
    assign mem_addr_o = r_mem_addr;
    assign busy_o     = r_busy;
    assign rwr_en_o   = r_rwr_en;
    assign dr_en_o    = r_rwr_en;
    assign rd_o       = r_rd_out;
    assign wr_data_o  = r_wr_data;

endmodule
